// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control FSM.
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY,
        DROP_PACKET
    } state_e;

endpackage

// File: rtl/router_fsm.sv
// Moore control FSM for the 1x3 router: header decode, load sequencing, full/parity handling.
// Optional ROUTER_FSM_DROP_INVALID_EN: invalid-address packets are swallowed in DROP_PACKET.
module router_fsm
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 write_enb_reg,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic [ADDR_W-1:0]    dest_addr
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   dest_addr_q, dest_addr_d;
    logic                addr_ok;

    assign addr_ok   = (32'(data_in) < NUM_PORTS);
    assign dest_addr = dest_addr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= DECODE_ADDRESS;
            dest_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            dest_addr_q <= dest_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_addr_d = dest_addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (addr_ok) begin
                        dest_addr_d = data_in;
                        state_d     = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
`ifdef ROUTER_FSM_DROP_INVALID_EN
                    else begin
                        state_d = DROP_PACKET;
                    end
`endif
                end
            end
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (fifo_empty[dest_addr_q]) state_d = LOAD_FIRST_DATA;
            end
            DROP_PACKET: begin
                if (!pkt_valid) state_d = DECODE_ADDRESS;
            end
            default:            state_d = DECODE_ADDRESS;
        endcase

        // A read-timeout on the port we are feeding aborts the packet; drops ignore it.
        if ((state_q != DECODE_ADDRESS) && (state_q != DROP_PACKET) && soft_reset[dest_addr_q])
            state_d = DECODE_ADDRESS;
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b0;
        case (state_q)
            DECODE_ADDRESS:     detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_TILL_EMPTY:    busy = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: per-cycle expected outputs queued at drive time, checked after the edge.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy;
    logic [1:0] dest_addr;

    router_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy), .dest_addr(dest_addr)
    );

    always #5 clock = ~clock;

    localparam int DA = 0, LFD = 1, LD = 2, FFS = 3, LAF = 4, LP = 5, CPE = 6, WTE = 7, DROP = 8;

    typedef struct {
        logic [7:0] outs;
        logic [1:0] dest;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    function automatic logic [7:0] outs_of(input int s);
        case (s)
            DA:      return 8'b1000_0000;
            LFD:     return 8'b0100_0001;
            LD:      return 8'b0010_0010;
            FFS:     return 8'b0000_1001;
            LAF:     return 8'b0001_0011;
            LP:      return 8'b0000_0011;
            CPE:     return 8'b0000_0101;
            WTE:     return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic step(input logic rst, input logic pv, input logic [1:0] din,
                        input logic full, input logic [2:0] empty, input logic [2:0] srst,
                        input logic pd, input logic lpv,
                        input int exp_state, input logic [1:0] exp_dest, input string tag);
        exp_t e, got;
        logic [7:0] obs;
        reset = rst; pkt_valid = pv; data_in = din; fifo_full = full;
        fifo_empty = empty; soft_reset = srst; parity_done = pd; low_pkt_valid = lpv;
        e.outs = outs_of(exp_state);
        e.dest = exp_dest;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        got = exp_q.pop_front();
        obs = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy};
        chk_cnt++;
        assert (obs === got.outs) pass_cnt++;
        else $error("FAIL %s outs observed %b expected %b", got.tag, obs, got.outs);
        chk_cnt++;
        assert (dest_addr === got.dest) pass_cnt++;
        else $error("FAIL %s dest_addr observed %0d expected %0d", got.tag, dest_addr, got.dest);
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;

        // reset state
        step(1, 0, 0, 0, 3'b111, 0, 0, 0, DA, 0, "reset0");
        step(1, 1, 1, 1, 3'b111, 3'b111, 1, 1, DA, 0, "reset1");
        step(0, 0, 1, 0, 3'b111, 0, 0, 0, DA, 0, "idle_no_valid");

        // normal packet to port 1 (header 8'h05), 4 payload bytes then parity
        step(0, 1, 1, 0, 3'b111, 0, 0, 0, LFD, 1, "hdr1_lfd");
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LD,  1, "hdr1_ld");
        step(0, 1, 2, 0, 3'b111, 0, 0, 0, LD,  1, "pay2");
        step(0, 1, 3, 0, 3'b111, 0, 0, 0, LD,  1, "pay3");
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LD,  1, "pay4");
        step(0, 0, 0, 0, 3'b111, 0, 0, 0, LP,  1, "parity_load");
        step(0, 0, 0, 0, 3'b111, 0, 0, 0, CPE, 1, "check_parity");
        step(0, 0, 0, 0, 3'b111, 0, 0, 0, DA,  1, "back_decode");

        // full handling on port 0
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LFD, 0, "hdr0_lfd");
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LD,  0, "hdr0_ld");
        step(0, 1, 0, 1, 3'b111, 0, 0, 0, FFS, 0, "full1");
        step(0, 1, 0, 1, 3'b111, 0, 0, 0, FFS, 0, "full2");
        step(0, 1, 0, 1, 3'b111, 0, 0, 0, FFS, 0, "full3");
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LAF, 0, "laf1");
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LD,  0, "laf_to_ld");
        step(0, 0, 0, 1, 3'b111, 0, 0, 0, FFS, 0, "full_beats_novalid");
        step(0, 0, 0, 0, 3'b111, 0, 0, 0, LAF, 0, "laf2");
        step(0, 0, 0, 0, 3'b111, 0, 0, 1, LP,  0, "laf_lowpv_lp");
        step(0, 0, 0, 1, 3'b111, 0, 0, 0, CPE, 0, "cpe2");
        step(0, 0, 0, 1, 3'b111, 0, 0, 0, FFS, 0, "cpe_full_ffs");
        step(0, 0, 0, 0, 3'b111, 0, 0, 0, LAF, 0, "laf3");
        step(0, 0, 0, 0, 3'b111, 0, 1, 1, DA,  0, "laf_parity_done");

        // port 2 busy until its FIFO drains
        step(0, 1, 2, 0, 3'b011, 0, 0, 0, WTE, 2, "wait1");
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 0, 3'b011, 0, 0, 0, WTE, 2, "wait_hold");
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LFD, 2, "wait_done");
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LD,  2, "wait_ld");
        step(0, 0, 0, 0, 3'b111, 0, 0, 0, LP,  2, "wait_lp");
        step(0, 0, 0, 0, 3'b111, 0, 0, 0, CPE, 2, "wait_cpe");
        step(0, 0, 0, 0, 3'b111, 0, 0, 0, DA,  2, "wait_da");

        // soft reset only honoured for the selected port
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LFD, 0, "sr_lfd");
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LD,  0, "sr_ld");
        step(0, 1, 0, 0, 3'b111, 3'b010, 0, 0, LD, 0, "sr_other_port");
        step(0, 1, 0, 0, 3'b111, 3'b001, 0, 0, DA, 0, "sr_own_port");

        // reset mid-packet wins over everything
        step(0, 1, 1, 0, 3'b111, 0, 0, 0, LFD, 1, "mid_lfd");
        step(0, 1, 0, 0, 3'b111, 0, 0, 0, LD,  1, "mid_ld");
        step(1, 1, 2, 1, 3'b000, 0, 1, 1, DA,  0, "mid_reset");

        // invalid address 3
`ifdef ROUTER_FSM_DROP_INVALID_EN
        step(0, 1, 3, 0, 3'b111, 0, 0, 0, DROP, 0, "inv_drop");
        step(0, 1, 1, 0, 3'b111, 3'b111, 0, 0, DROP, 0, "inv_drop_hold");
        step(0, 0, 0, 0, 3'b111, 3'b111, 0, 0, DA, 0, "inv_drop_exit");
`else
        step(0, 1, 3, 0, 3'b111, 0, 0, 0, DA, 0, "inv_ignored");
        step(0, 1, 3, 0, 3'b111, 0, 0, 0, DA, 0, "inv_ignored2");
`endif
        step(0, 1, 2, 0, 3'b111, 0, 0, 0, LFD, 2, "after_inv_hdr");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
